pio_host_link: RTL
==================

# pio_host_link

Host-side protocol engine for the 16-bit PIO handshake used by the FIR filter wrapper. In the transmit phase it streams N samples onto the wrapper's input PIO, inserting a separator before each sample and waiting for an acknowledge after each write. In the collect phase it captures N result words from the wrapper's output PIO and decodes the reserved zero encoding. It replaces the HPS in FPGA-only loopback benches and in standalone BIST builds.

## Interface
- N_LOG, 7: samples per run = 2**N_LOG; must equal the wrapper's SIGNAL_SIZE_LOG.
- TIMEOUT_CYCLES, 1024: acknowledge/result watchdog limit; used only when the watchdog is compiled in.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a run; ignored unless in IDLE.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample ready; high only in GET_SMP.
- s_data  in  16  sample value.
- pio_out  out  16  registered; drives the wrapper's data_in.
- pio_in  in  16  the wrapper's data_out, same clock domain.
- m_valid  out  1  one-cycle pulse per decoded result.
- m_data  out  16  decoded result; valid with m_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the Nth result is captured.
- err  out  1  sticky watchdog flag; cleared by rst or start.

## Operation
- Reserved codes: ACK = 0x8001, ZERO = 0x8000, SUB = 0x8002.
- Ack event: pio_in == ACK and prev_in != ACK. prev_in is pio_in registered every cycle.
- Word event: pio_in != prev_in, and pio_in is neither 0x0000 nor ACK.
- States:
  - IDLE: on start, clear the counters and err, then go to GET_SMP.
  - GET_SMP: on s_valid & s_ready, latch the sample and go to SEND_SEP. A sample equal to ACK is latched as SUB.
  - SEND_SEP: pio_out <= ACK; go to WAIT_SEP.
  - WAIT_SEP: on ack event, pio_out <= the latched sample; go to WAIT_SMP.
  - WAIT_SMP: on ack event, increment tx_cnt. Go to COLLECT if tx_cnt reaches 2**N_LOG, otherwise go to GET_SMP.
  - COLLECT: on word event, pulse m_valid with m_data = (pio_in == ZERO) ? 0x0000 : pio_in, and increment rx_cnt. After the (2**N_LOG)th word, go to DONE.
  - DONE: pulse done for one cycle; go to IDLE.
- The separator before every sample guarantees a detectable change, including for repeated samples and for the value 0x0000.
- Counters are N_LOG+1 bits wide, so the value 2**N_LOG is representable and no wrap occurs.
- pio_out holds its last value in IDLE. Consecutive runs require the wrapper to be reset.
- Ack events outside WAIT_SEP/WAIT_SMP and word events outside COLLECT are ignored.
- SUB (0x8002) received in COLLECT is delivered unchanged.

## Timing
- Reset values:
  - pio_out = 0x0000, prev_in = 0x0000.
  - s_ready = 0, m_valid = 0, m_data = 0x0000.
  - busy = 0, done = 0, err = 0.
  - state = IDLE.
- A synchronous rst mid-run aborts immediately to these values. No partial result is delivered.
- pio_out changes on the clock edge after the qualifying event.
  - SEND_SEP is a one-cycle state.
  - Each sample costs at least 1 (GET_SMP) + 1 (SEND_SEP) + ack latency + 1 + ack latency cycles.
- m_valid asserts on the clock edge after pio_in presents the word; result latency is 1 cycle.
- There is no result backpressure. Results arrive at most one every 3 cycles.
- Ack and word events in the same cycle cannot occur; the states are disjoint.

## Configuration
- PIO_HOST_TIMEOUT_EN defined:
  - A watchdog counts cycles in WAIT_SEP, WAIT_SMP and COLLECT, and restarts on every ack or word event.
  - On reaching TIMEOUT_CYCLES it sets err, pulses done and returns to IDLE.
- PIO_HOST_TIMEOUT_EN undefined:
  - There is no watchdog; err is tied to 0 and the engine waits indefinitely.

## Structure
- Package pio_link_pkg holds:
  - constants PIO_ACK, PIO_ZERO, PIO_SUB, PIO_WIDTH = 16;
  - the state enum. The FIR wrapper revision shares the same constants.
- Sub-module pio_event_detect holds prev_in and produces ack_evt and word_evt.

## Test plan
- N_LOG = 2, samples {1, 2, 3, 4}, looped back through a wrapper with taps 2, 6, 5, 6:
  - pio_out sequence is 8001, 0001, 8001, 0002, 8001, 0003, 8001, 0004;
  - 4 m_valid pulses, then done.
- Samples {0, 0, 0, 0}:
  - every 0x0000 write is acknowledged;
  - results are all 0x0000, each received as ZERO and decoded.
- Sample 0x8001 is driven onto pio_out as 0x8002; the wrapper counts it as a sample.
- s_valid held low for 20 cycles in GET_SMP: pio_out is stable and busy = 1; the run resumes when s_valid rises.
- rst asserted in COLLECT after 2 results: all outputs return to reset values the next cycle, and no further m_valid pulses appear.
- PIO_HOST_TIMEOUT_EN with TIMEOUT_CYCLES = 16 and pio_in stuck at 0x0000: err = 1 and done pulses 16 cycles after entering WAIT_SEP.

Source files
------------

// File: rtl/pio_link_pkg.sv
// Shared PIO handshake constants and host link state encoding.
// The FIR wrapper revision imports the same reserved codes.
package pio_link_pkg;

    localparam int unsigned PIO_WIDTH = 16;

    localparam logic [PIO_WIDTH-1:0] PIO_ACK  = 16'h8001;
    localparam logic [PIO_WIDTH-1:0] PIO_ZERO = 16'h8000;
    localparam logic [PIO_WIDTH-1:0] PIO_SUB  = 16'h8002;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_SMP,
        ST_SEND_SEP,
        ST_WAIT_SEP,
        ST_WAIT_SMP,
        ST_COLLECT,
        ST_DONE
    } link_state_e;

endpackage

// File: rtl/pio_event_detect.sv
// Edge detection on the wrapper's output PIO: acknowledge events and new result words.
module pio_event_detect
    import pio_link_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIO_WIDTH-1:0] pio_in,
    output logic                 ack_evt,
    output logic                 word_evt
);

    logic [PIO_WIDTH-1:0] prev_in;

    always_ff @(posedge clk) begin
        if (rst) prev_in <= '0;
        else     prev_in <= pio_in;
    end

    always_comb begin
        ack_evt  = (pio_in == PIO_ACK) && (prev_in != PIO_ACK);
        word_evt = (pio_in != prev_in) && (pio_in != '0) && (pio_in != PIO_ACK);
    end

endmodule

// File: rtl/pio_host_link.sv
// Host-side PIO protocol engine: streams 2**N_LOG samples out, collects as many results.
// Optional watchdog compiled in with PIO_HOST_TIMEOUT_EN.
module pio_host_link
    import pio_link_pkg::*;
#(
    parameter int unsigned N_LOG          = 7,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [PIO_WIDTH-1:0] s_data,
    output logic [PIO_WIDTH-1:0] pio_out,
    input  logic [PIO_WIDTH-1:0] pio_in,
    output logic                 m_valid,
    output logic [PIO_WIDTH-1:0] m_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned CW = N_LOG + 1;
    localparam logic [CW-1:0] N_SAMPLES = {1'b1, {N_LOG{1'b0}}};

    link_state_e          state, state_nxt;
    logic [CW-1:0]        tx_cnt, tx_cnt_nxt;
    logic [CW-1:0]        rx_cnt, rx_cnt_nxt;
    logic [PIO_WIDTH-1:0] smp, smp_nxt;
    logic [PIO_WIDTH-1:0] pio_out_nxt, m_data_nxt;
    logic                 m_valid_nxt;
    logic                 ack_evt, word_evt;
    logic                 timeout;

    pio_event_detect u_evt (
        .clk      (clk),
        .rst      (rst),
        .pio_in   (pio_in),
        .ack_evt  (ack_evt),
        .word_evt (word_evt)
    );

`ifdef PIO_HOST_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_cnt;
    logic          waiting;

    assign waiting = (state == ST_WAIT_SEP) || (state == ST_WAIT_SMP) || (state == ST_COLLECT);

    always_ff @(posedge clk) begin
        if (rst || !waiting || ack_evt || word_evt) wd_cnt <= '0;
        else                                        wd_cnt <= wd_cnt + 1'b1;
    end

    // Fires on the TIMEOUT_CYCLES-th quiet cycle so done lands exactly that many cycles in.
    assign timeout = waiting && !ack_evt && !word_evt && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst)                          err <= 1'b0;
        else if (state == ST_IDLE && start) err <= 1'b0;
        else if (timeout)                 err <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            tx_cnt  <= '0;
            rx_cnt  <= '0;
            smp     <= '0;
            pio_out <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            state   <= state_nxt;
            tx_cnt  <= tx_cnt_nxt;
            rx_cnt  <= rx_cnt_nxt;
            smp     <= smp_nxt;
            pio_out <= pio_out_nxt;
            m_valid <= m_valid_nxt;
            m_data  <= m_data_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tx_cnt_nxt  = tx_cnt;
        rx_cnt_nxt  = rx_cnt;
        smp_nxt     = smp;
        pio_out_nxt = pio_out;
        m_valid_nxt = 1'b0;
        m_data_nxt  = m_data;
        s_ready     = (state == ST_GET_SMP);
        busy        = (state != ST_IDLE);
        done        = (state == ST_DONE);

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    tx_cnt_nxt = '0;
                    rx_cnt_nxt = '0;
                    state_nxt  = ST_GET_SMP;
                end
            end
            ST_GET_SMP: begin
                if (s_valid) begin
                    smp_nxt   = (s_data == PIO_ACK) ? PIO_SUB : s_data;
                    state_nxt = ST_SEND_SEP;
                end
            end
            ST_SEND_SEP: begin
                pio_out_nxt = PIO_ACK;
                state_nxt   = ST_WAIT_SEP;
            end
            ST_WAIT_SEP: begin
                if (ack_evt) begin
                    pio_out_nxt = smp;
                    state_nxt   = ST_WAIT_SMP;
                end
            end
            ST_WAIT_SMP: begin
                if (ack_evt) begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                    state_nxt  = (tx_cnt_nxt == N_SAMPLES) ? ST_COLLECT : ST_GET_SMP;
                end
            end
            ST_COLLECT: begin
                if (word_evt) begin
                    m_valid_nxt = 1'b1;
                    m_data_nxt  = (pio_in == PIO_ZERO) ? '0 : pio_in;
                    rx_cnt_nxt  = rx_cnt + 1'b1;
                    if (rx_cnt_nxt == N_SAMPLES) state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        if (timeout) state_nxt = ST_DONE;
    end

endmodule
